// File: rtl/lab3_mem_blocking_cache_base_ctrl.sv
// Control unit for a blocking, write-back, write-allocate cache of 16 lines x 16 B.
// Every output is registered: it is decoded from the next state and loaded together with it.
module lab3_mem_blocking_cache_base_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        cachereq_val_i,
    output logic        cachereq_rdy_o,
    output logic        cacheresp_val_o,
    input  logic        cacheresp_rdy_i,
    output logic        memreq_val_o,
    input  logic        memreq_rdy_i,
    input  logic        memresp_val_i,
    output logic        memresp_rdy_o,

    output logic        cachereq_en_o,
    output logic        memresp_en_o,
    output logic        write_data_mux_sel_o,
    output logic        tag_array_ren_o,
    output logic        tag_array_wen_o,
    output logic        data_array_ren_o,
    output logic        data_array_wen_o,
    output logic [15:0] data_array_wben_o,
    output logic        read_data_reg_en_o,
    output logic        evict_addr_reg_en_o,
    output logic [1:0]  read_word_mux_sel_o,
    output logic        memreq_addr_mux_sel_o,
    output logic [2:0]  cacheresp_type_o,
    output logic [2:0]  memreq_type_o,
    output logic        hit_o,
    output logic        cacheresp_data_mux_sel_o,

    input  logic [2:0]  cachereq_type_i,
    input  logic [31:0] cachereq_addr_i,
    input  logic        tag_match_i,
    input  logic [3:0]  idx_i
);

    localparam logic [2:0] TYPE_READ  = 3'd0;
    localparam logic [2:0] TYPE_WRITE = 3'd1;
    localparam logic [2:0] TYPE_INIT  = 3'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_TC, S_IN, S_RD, S_WD, S_EP, S_ER, S_EW, S_RR, S_RW, S_RU, S_W
    } state_t;

    typedef struct packed {
        logic        cachereq_rdy;
        logic        cachereq_en;
        logic        cacheresp_val;
        logic [2:0]  cacheresp_type;
        logic        cacheresp_data_mux_sel;
        logic [1:0]  read_word_mux_sel;
        logic        memreq_val;
        logic [2:0]  memreq_type;
        logic        memreq_addr_mux_sel;
        logic        memresp_rdy;
        logic        memresp_en;
        logic        tag_array_ren;
        logic        tag_array_wen;
        logic        data_array_ren;
        logic        data_array_wen;
        logic [15:0] data_array_wben;
        logic        write_data_mux_sel;
        logic        read_data_reg_en;
        logic        evict_addr_reg_en;
    } ctrl_t;

    function automatic ctrl_t idle_ctrl();
        ctrl_t c;
        c              = '0;
        c.cachereq_rdy = 1'b1;
        c.cachereq_en  = 1'b1;
        return c;
    endfunction

    state_t      state_q, state_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [15:0] valid_q, dirty_q;
    logic        hit_q, hit_d;

    logic        is_write, is_init, line_valid, line_dirty, line_hit;
    logic [15:0] word_wben;
    logic        unused_addr_bits;

    // Any type other than write or init behaves as a read.
    assign is_write   = (cachereq_type_i == TYPE_WRITE);
    assign is_init    = (cachereq_type_i == TYPE_INIT);
    assign line_valid = valid_q[idx_i];
    assign line_dirty = dirty_q[idx_i];
    assign line_hit   = line_valid & tag_match_i;
    assign word_wben  = 16'h000F << {cachereq_addr_i[3:2], 2'b00};

    assign unused_addr_bits = ^{cachereq_addr_i[31:4], cachereq_addr_i[1:0]};

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        case (state_q)
            S_IDLE: if (cachereq_val_i) state_d = S_TC;
            S_TC: begin
                hit_d = is_init ? 1'b0 : line_hit;
                if (is_init)                      state_d = S_IN;
                else if (line_hit)                state_d = is_write ? S_WD : S_RD;
                else if (line_valid & line_dirty) state_d = S_EP;
                else                              state_d = S_RR;
            end
            S_IN, S_RD, S_WD: state_d = S_W;
            S_EP: state_d = S_ER;
            S_ER: if (memreq_rdy_i)  state_d = S_EW;
            S_EW: if (memresp_val_i) state_d = S_RR;
            S_RR: if (memreq_rdy_i)  state_d = S_RW;
            S_RW: if (memresp_val_i) state_d = S_RU;
            S_RU: state_d = is_write ? S_WD : S_RD;
            S_W: begin
                if (cacheresp_rdy_i) begin
                    state_d = S_IDLE;
                    hit_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decode the outputs that belong to the state being entered.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_IDLE: ctrl_d = idle_ctrl();
            S_TC:   ctrl_d.tag_array_ren = 1'b1;
            S_IN: begin
                ctrl_d.tag_array_wen   = 1'b1;
                ctrl_d.data_array_wen  = 1'b1;
                ctrl_d.data_array_wben = word_wben;
            end
            S_RD: begin
                ctrl_d.data_array_ren   = 1'b1;
                ctrl_d.read_data_reg_en = 1'b1;
            end
            S_WD: begin
                ctrl_d.data_array_wen  = 1'b1;
                ctrl_d.data_array_wben = word_wben;
            end
            S_EP: begin
                ctrl_d.data_array_ren    = 1'b1;
                ctrl_d.tag_array_ren     = 1'b1;
                ctrl_d.read_data_reg_en  = 1'b1;
                ctrl_d.evict_addr_reg_en = 1'b1;
            end
            S_ER: begin
                ctrl_d.memreq_val = 1'b1;
                ctrl_d.memreq_type = TYPE_WRITE;
            end
            S_EW: ctrl_d.memresp_rdy = 1'b1;
            S_RR: begin
                ctrl_d.memreq_val          = 1'b1;
                ctrl_d.memreq_type         = TYPE_READ;
                ctrl_d.memreq_addr_mux_sel = 1'b1;
            end
            S_RW: begin
                ctrl_d.memresp_rdy = 1'b1;
                ctrl_d.memresp_en  = 1'b1;
            end
            S_RU: begin
                ctrl_d.data_array_wen     = 1'b1;
                ctrl_d.data_array_wben    = 16'hFFFF;
                ctrl_d.write_data_mux_sel = 1'b1;
                ctrl_d.tag_array_wen      = 1'b1;
            end
            S_W: begin
                ctrl_d.cacheresp_val          = 1'b1;
                ctrl_d.cacheresp_type         = cachereq_type_i;
                ctrl_d.read_word_mux_sel      = cachereq_addr_i[3:2];
                ctrl_d.cacheresp_data_mux_sel = ~is_write & ~is_init;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ctrl_q  <= idle_ctrl();
            hit_q   <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            hit_q   <= hit_d;
            case (state_q)
                S_IN, S_RU: begin
                    valid_q[idx_i] <= 1'b1;
                    dirty_q[idx_i] <= 1'b0;
                end
                S_WD:    dirty_q[idx_i] <= 1'b1;
                default: ;
            endcase
        end
    end

    assign cachereq_rdy_o           = ctrl_q.cachereq_rdy;
    assign cachereq_en_o            = ctrl_q.cachereq_en;
    assign cacheresp_val_o          = ctrl_q.cacheresp_val;
    assign cacheresp_type_o         = ctrl_q.cacheresp_type;
    assign cacheresp_data_mux_sel_o = ctrl_q.cacheresp_data_mux_sel;
    assign read_word_mux_sel_o      = ctrl_q.read_word_mux_sel;
    assign memreq_val_o             = ctrl_q.memreq_val;
    assign memreq_type_o            = ctrl_q.memreq_type;
    assign memreq_addr_mux_sel_o    = ctrl_q.memreq_addr_mux_sel;
    assign memresp_rdy_o            = ctrl_q.memresp_rdy;
    assign memresp_en_o             = ctrl_q.memresp_en;
    assign tag_array_ren_o          = ctrl_q.tag_array_ren;
    assign tag_array_wen_o          = ctrl_q.tag_array_wen;
    assign data_array_ren_o         = ctrl_q.data_array_ren;
    assign data_array_wen_o         = ctrl_q.data_array_wen;
    assign data_array_wben_o        = ctrl_q.data_array_wben;
    assign write_data_mux_sel_o     = ctrl_q.write_data_mux_sel;
    assign read_data_reg_en_o       = ctrl_q.read_data_reg_en;
    assign evict_addr_reg_en_o      = ctrl_q.evict_addr_reg_en;
    assign hit_o                    = hit_q;

endmodule

// File: tb/tb_lab3_mem_blocking_cache_base_ctrl.sv
// Bench for the blocking cache controller: directed table, reset-abort sequence, random traffic.
module tb_lab3_mem_blocking_cache_base_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cachereq_val = 1'b0, cacheresp_rdy = 1'b0;
    logic        memreq_rdy = 1'b0, memresp_val = 1'b0;
    logic        cachereq_rdy, cacheresp_val, memreq_val, memresp_rdy;
    logic        cachereq_en, memresp_en, write_data_mux_sel;
    logic        tag_array_ren, tag_array_wen, data_array_ren, data_array_wen;
    logic [15:0] data_array_wben;
    logic        read_data_reg_en, evict_addr_reg_en;
    logic [1:0]  read_word_mux_sel;
    logic        memreq_addr_mux_sel;
    logic [2:0]  cacheresp_type, memreq_type;
    logic        hit, cacheresp_data_mux_sel;
    logic [2:0]  req_type = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic        tag_match;
    logic [3:0]  idx;

    // Reference cache state: which lines hold which tag, and whether they are dirty.
    logic [15:0] m_valid, m_dirty;
    logic [23:0] m_tag [16];

    int errors = 0;
    int checks = 0;

    assign idx       = req_addr[7:4];
    assign tag_match = (m_tag[req_addr[7:4]] == req_addr[31:8]);

    always #5 clk = ~clk;

    lab3_mem_blocking_cache_base_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cachereq_val_i(cachereq_val), .cachereq_rdy_o(cachereq_rdy),
        .cacheresp_val_o(cacheresp_val), .cacheresp_rdy_i(cacheresp_rdy),
        .memreq_val_o(memreq_val), .memreq_rdy_i(memreq_rdy),
        .memresp_val_i(memresp_val), .memresp_rdy_o(memresp_rdy),
        .cachereq_en_o(cachereq_en), .memresp_en_o(memresp_en),
        .write_data_mux_sel_o(write_data_mux_sel),
        .tag_array_ren_o(tag_array_ren), .tag_array_wen_o(tag_array_wen),
        .data_array_ren_o(data_array_ren), .data_array_wen_o(data_array_wen),
        .data_array_wben_o(data_array_wben),
        .read_data_reg_en_o(read_data_reg_en), .evict_addr_reg_en_o(evict_addr_reg_en),
        .read_word_mux_sel_o(read_word_mux_sel), .memreq_addr_mux_sel_o(memreq_addr_mux_sel),
        .cacheresp_type_o(cacheresp_type), .memreq_type_o(memreq_type),
        .hit_o(hit), .cacheresp_data_mux_sel_o(cacheresp_data_mux_sel),
        .cachereq_type_i(req_type), .cachereq_addr_i(req_addr),
        .tag_match_i(tag_match), .idx_i(idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_rdy_en"}, {30'd0, cachereq_rdy, cachereq_en}, 32'd3);
        chk({name, "_others"}, {cacheresp_val, memreq_val, memresp_rdy, memresp_en,
                                write_data_mux_sel, tag_array_ren, tag_array_wen,
                                data_array_ren, data_array_wen, data_array_wben,
                                read_data_reg_en, evict_addr_reg_en, read_word_mux_sel,
                                memreq_addr_mux_sel, cacheresp_type, memreq_type, hit,
                                cacheresp_data_mux_sel}, 32'd0);
    endtask

    // One complete transaction; s = memreq_rdy stall, l = memresp latency, stall = cacheresp_rdy stall.
    task automatic run_txn(input logic [2:0] t, input logic [31:0] a, input int s, input int l,
                           input int stall, output logic got_hit, output int got_wr, output int got_rd);
        logic [3:0]  ix;
        logic [23:0] tg;
        logic        is_wr, is_in, m_hit, miss, ev, exp_wr_req;
        logic [16:0] exp_wen;
        int          exp_k, exp_nwen, k, cs, cl, w, nwen;
        bit          seen, done;
        ix = a[7:4];
        tg = a[31:8];
        is_wr = (t == 3'd1);
        is_in = (t == 3'd2);
        m_hit = !is_in && m_valid[ix] && (m_tag[ix] == tg);
        miss  = !is_in && !m_hit;
        ev    = miss && m_valid[ix] && m_dirty[ix];
        exp_k = 3 + (miss ? 3 + s + l : 0) + (ev ? 3 + s + l : 0);
        exp_nwen = (is_in || (m_hit && is_wr)) ? 1 : m_hit ? 0 : (is_wr ? 2 : 1);
        got_hit = 1'b0; got_wr = 0; got_rd = 0;
        @(negedge clk);
        chk("req_rdy_idle", cachereq_rdy, 1);
        req_type = t; req_addr = a; cachereq_val = 1'b1;
        @(posedge clk);
        k = 0; cs = s; cl = l; w = 0; nwen = 0; seen = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            k++;
            cachereq_val = 1'b0; memreq_rdy = 1'b0; memresp_val = 1'b0; cacheresp_rdy = 1'b0;
            if (k > 200) begin
                errors++; checks++;
                $display("FAIL txn_timeout: no response after %0d cycles, expected at %0d", k, exp_k);
                break;
            end
            chk("cachereq_rdy_busy", cachereq_rdy, 0);
            if (memreq_val) begin
                exp_wr_req = ev && (got_wr == 0);
                chk("memreq_type", memreq_type, exp_wr_req ? 1 : 0);
                chk("memreq_addr_sel", memreq_addr_mux_sel, !exp_wr_req);
                if (cs > 0) cs--;
                else begin
                    memreq_rdy = 1'b1; cs = s;
                    if (exp_wr_req) got_wr++; else got_rd++;
                end
            end
            if (memresp_rdy) begin
                chk("memresp_en", memresp_en, got_rd > 0);
                if (cl > 0) cl--;
                else begin memresp_val = 1'b1; cl = l; end
            end
            if (data_array_wen) begin
                exp_wen = (miss && nwen == 0) ? {1'b1, 16'hFFFF} : {1'b0, 16'h000F << (4 * a[3:2])};
                chk("data_wsel_wben", {write_data_mux_sel, data_array_wben}, exp_wen);
                nwen++;
            end
            if (cacheresp_val) begin
                if (!seen) begin chk("resp_latency", k, exp_k); seen = 1; end
                chk("resp_type", cacheresp_type, t);
                chk("resp_hit", hit, m_hit);
                chk("resp_data_sel", cacheresp_data_mux_sel, !is_wr && !is_in);
                chk("resp_word_sel", read_word_mux_sel, a[3:2]);
                if (w < stall) w++;
                else begin cacheresp_rdy = 1'b1; got_hit = hit; done = 1; end
            end
        end
        @(posedge clk);
        #1 cacheresp_rdy = 1'b0;
        chk("n_memreq_wr", got_wr, ev);
        chk("n_memreq_rd", got_rd, miss);
        chk("n_data_wen", nwen, exp_nwen);
        if (is_in) begin
            m_valid[ix] = 1'b1; m_dirty[ix] = 1'b0; m_tag[ix] = tg;
        end else if (m_hit) begin
            if (is_wr) m_dirty[ix] = 1'b1;
        end else begin
            m_valid[ix] = 1'b1; m_dirty[ix] = is_wr; m_tag[ix] = tg;
        end
    endtask

    typedef struct {
        logic [2:0]  t;
        logic [31:0] a;
        int          s, l, stall;
        logic        hit;
        int          wr, rd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic gh;
        int   gw, gr, k, r;
        bit   found;
        logic [2:0]  rt;
        logic [23:0] rtag;

        m_valid = '0; m_dirty = '0;
        for (int i = 0; i < 16; i++) m_tag[i] = 24'd0;

        //           type   addr          s  l  stall hit wr rd
        tbl[0] = '{3'd2, 32'h0000_1000, 0, 0, 0, 1'b0, 0, 0};
        tbl[1] = '{3'd0, 32'h0000_1000, 0, 0, 5, 1'b1, 0, 0};
        tbl[2] = '{3'd0, 32'h0000_2004, 0, 0, 0, 1'b0, 0, 1};
        tbl[3] = '{3'd1, 32'h0000_1000, 1, 2, 0, 1'b0, 0, 1};
        tbl[4] = '{3'd1, 32'h0000_1008, 0, 0, 0, 1'b1, 0, 0};
        tbl[5] = '{3'd0, 32'h0000_1100, 2, 1, 0, 1'b0, 1, 1};
        tbl[6] = '{3'd0, 32'h0000_110C, 0, 0, 1, 1'b1, 0, 0};
        tbl[7] = '{3'd5, 32'h0000_1104, 0, 0, 0, 1'b1, 0, 0};
        tbl[8] = '{3'd1, 32'h0000_0030, 0, 1, 0, 1'b0, 0, 1};
        tbl[9] = '{3'd0, 32'h0000_0034, 0, 0, 0, 1'b1, 0, 0};

        repeat (2) @(negedge clk);
        chk_idle_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("after_reset");

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].t, tbl[i].a, tbl[i].s, tbl[i].l, tbl[i].stall, gh, gw, gr);
            chk($sformatf("tbl%0d_hit", i), gh, tbl[i].hit);
            chk($sformatf("tbl%0d_memwr", i), gw, tbl[i].wr);
            chk($sformatf("tbl%0d_memrd", i), gr, tbl[i].rd);
        end

        // Reset pulse while waiting for refill data; the line must not become valid.
        @(negedge clk);
        req_type = 3'd0; req_addr = 32'h0000_1000; cachereq_val = 1'b1;
        @(posedge clk);
        k = 0; found = 0;
        while (!found && k < 50) begin
            @(negedge clk);
            k++;
            cachereq_val = 1'b0;
            memreq_rdy = memreq_val;
            if (memresp_rdy && memresp_en) found = 1;
        end
        chk("reached_refill_wait", found, 1);
        memreq_rdy = 1'b0;
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        m_valid = '0; m_dirty = '0;
        @(negedge clk);
        chk_idle_outputs("after_abort");
        run_txn(3'd0, 32'h0000_1000, 0, 0, 0, gh, gw, gr);
        chk("post_abort_hit", gh, 0);
        chk("post_abort_memrd", gr, 1);

        for (int n = 0; n < 60; n++) begin
            r  = $urandom_range(0, 9);
            rt = (r < 4) ? 3'd0 : (r < 7) ? 3'd1 : (r == 7) ? 3'd2 : 3'($urandom_range(3, 7));
            case ($urandom_range(0, 2))
                0:       rtag = 24'h10;
                1:       rtag = 24'h11;
                default: rtag = 24'h20;
            endcase
            run_txn(rt, {rtag, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00},
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), gh, gw, gr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
